cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Sits directly downstream of the per-class execution units (ALU, memory, multiply, divide, jump). Each unit exposes a cdb_request and a cdb_out payload.
- Each cycle the arbiter picks at most one requesting unit using a rotating round-robin priority, then drives the registered common data bus cdb = {on, payload}.
- The units sample cdb on negedge clk; a unit drops its request once it sees its own FU tag with the on bit set.
- A saturating counter of contention cycles is kept for performance visibility.

Parameters:
- NUM_UNITS, 5, number of requesting units; unit index 0 has highest priority after reset.
- PAYLOAD_W, 38, width of one unit payload = NUM_CDBBITS-1, laid out as {FU tag[2:0], RS one-hot[2:0], data[31:0]}.
- CNT_W, 16, width of the contention counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NUM_UNITS  per-unit cdb_request; bit i belongs to unit i.
- payload  input  NUM_UNITS*PAYLOAD_W  flattened cdb_out; unit i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- cdb  output  PAYLOAD_W+1  registered bus: MSB = CDB_ON bit, low bits = winner payload.
- grant  output  NUM_UNITS  registered one-hot winner of the current cdb beat; all zero when idle.
- conflict_cnt  output  CNT_W  saturating count of cycles where more than one req bit was high.

Behaviour:
- Reset (async, rst=1):
  - cdb=0 (on=0, tag, RS field and data all 0), grant=0, conflict_cnt=0.
  - Internal pointer ptr=0.
  - Reset asserted mid-beat kills the beat immediately. The pending unit keeps requesting and is re-arbitrated after reset.
- Each posedge with rst=0, with R = req sampled at that edge:
  - R==0:
    - cdb <= 0; grant <= 0; ptr unchanged.
  - R!=0:
    - Winner w = first index i with R[i]=1, searching i = ptr, ptr+1, … NUM_UNITS-1, 0, … ptr-1 (wrap-around).
    - cdb <= {1'b1, payload[w]}; grant <= one-hot(w).
    - ptr <= (w+1) mod NUM_UNITS. When w = NUM_UNITS-1, ptr wraps to 0.
  - Popcount(R) >= 2: conflict_cnt <= conflict_cnt+1, holding at all-ones (no wrap). Otherwise unchanged.
- Latency:
  - A request present at posedge t appears on cdb during cycle t to t+1, i.e. one clock after sampling.
  - Each beat lasts exactly one clock. The bus is never held longer, even when the same unit still requests.
- Handshake contract:
  - Units see the beat at the negedge inside it and must deassert req before the next posedge unless a new result is ready.
  - A req still high at the following posedge is treated as a new result and arbitrated normally.
  - Because ptr has advanced, the same unit wins back-to-back only if no other unit requests.
- Payload is taken at the sampling posedge. Changes to payload after that edge do not alter the beat in flight.
- Fairness: with all NUM_UNITS requesting continuously, every unit is granted exactly once in any NUM_UNITS consecutive beats.
- Invariants:
  - grant is always zero or one-hot.
  - grant!=0 if and only if cdb MSB=1.
  - The payload RS/tag fields are forwarded unmodified; the arbiter never decodes them.

Test Plan:
1. Reset, then idle: rst pulse, req=0 for 10 cycles -> cdb=0, grant=0, conflict_cnt=0 throughout, including while rst is high between edges.
2. Single requester: req=5'b00100 for one edge, payload[2]={3'd2,3'b100,32'h0000_0006} -> next cycle cdb={1,3'd2,3'b100,32'h6}, grant=5'b00100; following cycle cdb=0.
3. Round-robin rotation: req=5'b11111 held 10 cycles, payloads carry data=i -> grant sequence 0,1,2,3,4,0,1,2,3,4; conflict_cnt=10.
4. Wrap and pointer skip: after a grant to unit 3 (ptr=4), req=5'b01001 -> unit 0 wins (4 empty, wrap to 0); next edge with req=5'b01000 -> unit 3 wins.
5. Handshake with unit_mul-style requester: unit 2 holds req until it samples its tag on cdb at negedge, while unit 4 requests in parallel -> both broadcast exactly once, unit 2 never duplicated.
6. Saturation and mid-beat reset: CNT_W=4, req=5'b00011 for 20 cycles -> conflict_cnt stops at 4'hF; assert rst between posedges during a beat -> cdb, grant, conflict_cnt go to 0 immediately.

Source files
------------

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Round-robin arbiter for the common data bus. Each cycle it picks at most
//   one requesting execution unit and drives the registered bus
//   cdb = {on, payload}. The search starts at a rotating pointer, so a unit
//   that has just won has the lowest priority on the next beat. A saturating
//   counter records the cycles in which two or more units requested at once.
//
// Ports
//   clk          in   clock, all state updates on posedge
//   rst          in   asynchronous active-high reset
//   req          in   [NUM_UNITS]           per-unit bus request
//   payload      in   [NUM_UNITS*PAYLOAD_W] unit i at [i*PAYLOAD_W +: PAYLOAD_W]
//   cdb          out  [PAYLOAD_W+1]         {on, winner payload}, registered
//   grant        out  [NUM_UNITS]           one-hot winner of the current beat
//   conflict_cnt out  [CNT_W]               saturating contention-cycle count
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_UNITS = 5,
    parameter int PAYLOAD_W = 38,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_UNITS-1:0]           req,
    input  logic [NUM_UNITS*PAYLOAD_W-1:0] payload,
    output logic [PAYLOAD_W:0]             cdb,
    output logic [NUM_UNITS-1:0]           grant,
    output logic [CNT_W-1:0]               conflict_cnt
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [PTR_W-1:0]     r_ptr;
    logic [PAYLOAD_W:0]   r_cdb;
    logic [NUM_UNITS-1:0] r_grant;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_any;
    logic                 w_multi;
    logic                 w_found;
    logic [PTR_W-1:0]     w_cand;
    logic [PTR_W-1:0]     w_win;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic [NUM_UNITS-1:0] w_win_oh;
    logic [PAYLOAD_W-1:0] w_win_payload;

    assign w_any = |req;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = |(req & (req - 1'b1));

    // Walk the units starting at the pointer, wrapping past the last index;
    // the first requester seen wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_cand = PTR_W'((int'(r_ptr) + k) % NUM_UNITS);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_win_oh      = NUM_UNITS'(1) << w_win;
    assign w_win_payload = payload[int'(w_win)*PAYLOAD_W +: PAYLOAD_W];
    assign w_ptr_nxt     = (w_win == PTR_W'(NUM_UNITS-1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_cdb   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
        end else begin
            // A beat lasts one clock; a request still high next edge is a new result.
            if (w_any) begin
                r_cdb   <= {1'b1, w_win_payload};
                r_grant <= w_win_oh;
                r_ptr   <= w_ptr_nxt;
            end else begin
                r_cdb   <= '0;
                r_grant <= '0;
            end
            if (w_multi && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cdb          = r_cdb;
    assign grant        = r_grant;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//   Self-checking bench for cdb_arbiter: table-driven rotation/wrap vectors,
//   hand-written reset, single-requester, handshake, saturation and
//   mid-beat-reset sequences, then randomized traffic against a reference
//   model built from the arbitration rules.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int N  = 5;
    localparam int P  = 38;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*P-1:0]   payload;
    logic [P:0]       cdb;
    logic [N-1:0]     grant;
    logic [CW-1:0]    conflict_cnt;

    logic [P-1:0]     pl [N];
    int               checks = 0;
    int               errors = 0;
    int               m_ptr;
    int               m_cnt;

    typedef struct {
        logic [N-1:0] r;
        logic [N-1:0] g;
        int           c;
    } vec_t;
    vec_t tbl [14];

    cdb_arbiter #(.NUM_UNITS(N), .PAYLOAD_W(P), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .payload      (payload),
        .cdb          (cdb),
        .grant        (grant),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic flatten();
        for (int i = 0; i < N; i++) payload[i*P +: P] = pl[i];
    endtask

    // Apply req/payload, let one posedge sample them, return 1 time unit later.
    task automatic drive(input logic [N-1:0] r);
        req = r;
        flatten();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        #2;
        chk("rst_cdb", 64'(cdb), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_cnt", 64'(conflict_cnt), 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    // Reference: scan from ptr with wrap, winner moves ptr past itself;
    // contention counter saturates at all-ones.
    task automatic model(input logic [N-1:0] r, output logic [N-1:0] eg, output logic [P:0] ec);
        int idx;
        eg = '0;
        ec = '0;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (r[idx]) begin
                eg[idx] = 1'b1;
                ec      = {1'b1, pl[idx]};
                m_ptr   = (idx + 1) % N;
                break;
            end
        end
        if ($countones(r) >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    function automatic logic [P:0] beat_of(input logic [N-1:0] g);
        logic [P:0] b;
        b = '0;
        for (int i = 0; i < N; i++) if (g[i]) b = {1'b1, pl[i]};
        return b;
    endfunction

    initial begin
        logic [N-1:0] eg;
        logic [P:0]   ec;
        logic [N-1:0] r;
        int           n2, n4;
        logic [2:0]   tag;

        rst = 1'b1;
        req = '0;
        for (int i = 0; i < N; i++) pl[i] = {3'(i), 3'(1 << (i % 3)), 32'(i)};
        flatten();

        // 1: reset then idle
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive('0);
            chk("idle_cdb", 64'(cdb), 64'd0);
            chk("idle_grant", 64'(grant), 64'd0);
            chk("idle_cnt", 64'(conflict_cnt), 64'd0);
        end

        // 2: single requester
        pl[2] = {3'd2, 3'b100, 32'h0000_0006};
        drive(5'b00100);
        chk("single_cdb", 64'(cdb), 64'({1'b1, 3'd2, 3'b100, 32'h6}));
        chk("single_grant", 64'(grant), 64'(5'b00100));
        drive('0);
        chk("single_after", 64'(cdb), 64'd0);
        pl[2] = {3'd2, 3'b100, 32'd2};

        // 3/4: rotation, wrap and pointer skip
        for (int k = 0; k < 10; k++) tbl[k] = '{5'b11111, 5'(1 << (k % 5)), k + 1};
        tbl[10] = '{5'b01000, 5'b01000, 10};
        tbl[11] = '{5'b01001, 5'b00001, 11};
        tbl[12] = '{5'b01000, 5'b01000, 11};
        tbl[13] = '{5'b00000, 5'b00000, 11};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r);
            chk($sformatf("tbl%0d_grant", i), 64'(grant), 64'(tbl[i].g));
            chk($sformatf("tbl%0d_cdb", i), 64'(cdb), 64'(beat_of(tbl[i].g)));
            chk($sformatf("tbl%0d_cnt", i), 64'(conflict_cnt), 64'(tbl[i].c));
        end

        // 5: handshake; units drop req after seeing their tag at negedge
        do_reset();
        n2 = 0;
        n4 = 0;
        req = 5'b10100;
        flatten();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cdb[P]) begin
                tag = cdb[P-1 -: 3];
                if (tag == 3'd2) begin n2++; req[2] = 1'b0; end
                if (tag == 3'd4) begin n4++; req[4] = 1'b0; end
            end
        end
        chk("hs_unit2_beats", 64'(n2), 64'd1);
        chk("hs_unit4_beats", 64'(n4), 64'd1);
        chk("hs_req_done", 64'(req), 64'd0);

        // 6: saturation, then mid-beat reset
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            drive(5'b00011);
            chk($sformatf("sat%0d_cnt", k), 64'(conflict_cnt), 64'((k > 15) ? 15 : k));
            chk($sformatf("sat%0d_grant", k), 64'(grant), 64'((k % 2) ? 5'b00001 : 5'b00010));
        end
        do_reset();
        drive(5'b00011);
        chk("mid_pre_on", 64'(cdb[P]), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_cdb", 64'(cdb), 64'd0);
        chk("mid_grant", 64'(grant), 64'd0);
        chk("mid_cnt", 64'(conflict_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(5'b00011);
        chk("mid_rearb_grant", 64'(grant), 64'(5'b00001));
        chk("mid_rearb_cnt", 64'(conflict_cnt), 64'd1);

        // randomized traffic vs reference model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            r = N'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            if ($urandom_range(0, 3) == 0) r = '1;
            for (int i = 0; i < N; i++) pl[i] = P'({$urandom, $urandom});
            model(r, eg, ec);
            drive(r);
            chk("rnd_grant", 64'(grant), 64'(eg));
            chk("rnd_cdb", 64'(cdb), 64'(ec));
            chk("rnd_cnt", 64'(conflict_cnt), 64'(m_cnt));
            chk("rnd_onehot", 64'($onehot0(grant)), 64'd1);
            // payload change after the sampling edge must not touch the beat
            for (int i = 0; i < N; i++) payload[i*P +: P] = P'({$urandom, $urandom});
            #1;
            chk("rnd_hold", 64'(cdb), 64'(ec));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
